// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI initiator.
package spi_pkg;

    localparam int unsigned CMD_W  = 10;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        WAIT,
        RECV,
        END
    } state_e;

    // Opcode field of a host command word.
    function automatic opcode_e cmd_opcode(input logic [CMD_W-1:0] cmd);
        return opcode_e'(cmd[CMD_W-1 -: 2]);
    endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for the SPI initiator: TX word (MSB out), RX byte (MSB in)
// and the down-counter that paces both phases.
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CMD_W-1:0]  tx_word,
    input  logic              tx_shift,
    input  logic              rx_shift,
    input  logic              miso,
    input  logic              cnt_load,
    input  logic [3:0]        cnt_init,
    output logic              mosi_bit,
    output logic [DATA_W-1:0] rx_next,
    output logic [3:0]        cnt
);

    logic [CMD_W-1:0]  tx_q;
    logic [DATA_W-1:0] rx_q;

    // TX/RX shift registers and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '0;
            rx_q <= '0;
            cnt  <= '0;
        end else begin
            if (load) begin
                tx_q <= tx_word;
            end else if (tx_shift) begin
                tx_q <= {tx_q[CMD_W-2:0], 1'b0};
            end
            if (rx_shift) begin
                rx_q <= rx_next;
            end
            if (cnt_load) begin
                cnt <= cnt_init;
            end else if ((tx_shift || rx_shift) && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign mosi_bit = tx_q[CMD_W-1];
    assign rx_next  = {rx_q[DATA_W-2:0], miso};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator sharing clk with the slave: frames 10-bit commands on
// SS_n/MOSI and captures an 8-bit reply from MISO for RD_DATA.
// Optional feature: SPI_MASTER_SEQ_CHK_EN rejects RD_DATA that is not
// preceded by a completed RD_ADDR (err pulse, no frame).
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned TURNAROUND = 2,
    parameter int unsigned GAP        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              err,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int unsigned WCNT_W = 16;

    state_e            state, state_nx;
    opcode_e           op_q;
    logic [WCNT_W-1:0] wcnt, wcnt_init;
    logic              wcnt_load;
    logic              accept, reject;
    logic              sh_load, tx_shift, rx_shift, cnt_load, capture;
    logic [3:0]        cnt_init, bit_cnt;
    logic              mosi_bit;
    logic [DATA_W-1:0] rx_next;

    assign accept = cmd_valid && (state == IDLE);

`ifdef SPI_MASTER_SEQ_CHK_EN
    logic rd_addr_seen;
    logic rd_addr_done;

    assign reject       = accept && (cmd_opcode(cmd_data) == RD_DATA) && !rd_addr_seen;
    assign rd_addr_done = (state == SHIFT) && (bit_cnt == '0) && (op_q == RD_ADDR);

    // Sequence flag and one-cycle rejection pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_seen <= 1'b0;
            err          <= 1'b0;
        end else begin
            err <= reject;
            if (capture) begin
                rd_addr_seen <= 1'b0;
            end else if (rd_addr_done) begin
                rd_addr_seen <= 1'b1;
            end
        end
    end
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif

    spi_master_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .tx_word  (cmd_data),
        .tx_shift (tx_shift),
        .rx_shift (rx_shift),
        .miso     (MISO),
        .cnt_load (cnt_load),
        .cnt_init (cnt_init),
        .mosi_bit (mosi_bit),
        .rx_next  (rx_next),
        .cnt      (bit_cnt)
    );

    // Next-state and per-state datapath controls.
    always_comb begin
        state_nx  = state;
        sh_load   = 1'b0;
        tx_shift  = 1'b0;
        rx_shift  = 1'b0;
        cnt_load  = 1'b0;
        cnt_init  = '0;
        wcnt_load = 1'b0;
        wcnt_init = '0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    sh_load = 1'b1;
                    if (reject) begin
                        // Rejected command skips the frame but still honours the gap.
                        state_nx  = END;
                        wcnt_load = 1'b1;
                        wcnt_init = WCNT_W'(GAP - 1);
                    end else begin
                        state_nx = START;
                    end
                end
            end
            START: begin
                cnt_load = 1'b1;
                cnt_init = 4'(CMD_W - 1);
                state_nx = SHIFT;
            end
            SHIFT: begin
                tx_shift = 1'b1;
                if (bit_cnt == '0) begin
                    wcnt_load = 1'b1;
                    if (op_q == RD_DATA) begin
                        state_nx  = WAIT;
                        wcnt_init = WCNT_W'(TURNAROUND - 1);
                    end else begin
                        state_nx  = END;
                        wcnt_init = WCNT_W'(GAP - 1);
                    end
                end
            end
            WAIT: begin
                if (wcnt == '0) begin
                    state_nx = RECV;
                    cnt_load = 1'b1;
                    cnt_init = 4'(DATA_W - 1);
                end
            end
            RECV: begin
                rx_shift = 1'b1;
                if (bit_cnt == '0) begin
                    capture   = 1'b1;
                    state_nx  = END;
                    wcnt_load = 1'b1;
                    wcnt_init = WCNT_W'(GAP - 1);
                end
            end
            END: begin
                if (wcnt == '0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, latched opcode, wait/gap counter and reply registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= WR_ADDR;
            wcnt      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= cmd_opcode(cmd_data);
            end
            if (wcnt_load) begin
                wcnt <= wcnt_init;
            end else if (wcnt != '0) begin
                wcnt <= wcnt - 1'b1;
            end
            rsp_valid <= capture;
            if (capture) begin
                rsp_data <= rx_next;
            end
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign SS_n      = !(state inside {START, SHIFT, WAIT, RECV});
    assign MOSI      = (state == START || state == SHIFT) ? mosi_bit : 1'b0;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl with a behavioural SPI slave.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int unsigned T = 2;
    localparam int unsigned G = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [9:0]  cmd_data = '0;
    logic        MISO = 1'b0;
    logic        cmd_ready, rsp_valid, busy, err, SS_n, MOSI;
    logic [7:0]  rsp_data;

    spi_master_ctrl #(.TURNAROUND(T), .GAP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .err       (err),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  cmd;
        int unsigned len;
        logic [7:0]  reply;
    } frame_t;

    typedef struct {
        logic [7:0]  data;
        int unsigned at;
    } rsp_t;

    frame_t      frame_q[$];
    rsp_t        rsp_q[$];
    int unsigned err_q[$];
`ifdef SPI_MASTER_SEQ_CHK_EN
    bit          seen = 1'b0;
`endif

    // Slave model and output monitor
    int unsigned low_cnt = 0;
    int unsigned high_cnt = 0;
    logic [10:0] bits = '0;
    bit          tail_bad = 1'b0;
    bit          had_frame = 1'b0;
    frame_t      mf;
    rsp_t        mr;
    int unsigned me;
    int          k;

    always @(negedge clk) begin
        if (!rst_n) begin
            low_cnt   = 0;
            high_cnt  = 0;
            had_frame = 1'b0;
            MISO      = 1'($urandom_range(0, 1));
        end else begin
            if (SS_n === 1'b0) begin
                if (low_cnt == 0) begin
                    tail_bad = 1'b0;
                    if (had_frame) chk("gap", 32'(high_cnt >= G), 1);
                end
                if (low_cnt < 11) bits = {bits[9:0], MOSI};
                else if (MOSI !== 1'b0) tail_bad = 1'b1;
                k = int'(low_cnt) - int'(11 + T);
                if (frame_q.size() > 0 && k >= 0 && k < 8)
                    MISO = frame_q[0].reply[7 - k];
                else
                    MISO = 1'($urandom_range(0, 1));
                low_cnt++;
                high_cnt = 0;
            end else begin
                if (low_cnt != 0) begin
                    if (frame_q.size() == 0) begin
                        chk("frame_spurious", 1, 0);
                    end else begin
                        mf = frame_q.pop_front();
                        chk("frame_bits", 32'(bits), 32'({mf.cmd[9], mf.cmd}));
                        chk("frame_len", low_cnt, mf.len);
                        chk("frame_tail", 32'(tail_bad), 0);
                    end
                    had_frame = 1'b1;
                    low_cnt   = 0;
                end
                chk("mosi_idle", 32'(MOSI), 0);
                high_cnt++;
                MISO = 1'($urandom_range(0, 1));
            end
            if (rsp_valid !== 1'b0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_spurious", 32'(rsp_valid), 0);
                end else begin
                    mr = rsp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(mr.data));
                    chk("rsp_cycle", cyc, mr.at);
                end
            end
            if (err !== 1'b0) begin
                if (err_q.size() == 0) begin
                    chk("err_spurious", 32'(err), 0);
                end else begin
                    me = err_q.pop_front();
                    chk("err_cycle", cyc, me);
                end
            end
        end
    end

    // Issue one command; returns at the negedge after accept.
    task automatic send(input logic [9:0] cmd, input logic [7:0] reply,
                        input bit wait_done, output int unsigned acc);
        bit          framed;
        bit          rdy;
        int unsigned c;
        int unsigned lat;
        bit          is_rd;
        rdy    = 1'b0;
        c      = 0;
        is_rd  = (cmd[9:8] == 2'b11);
        framed = 1'b1;
`ifdef SPI_MASTER_SEQ_CHK_EN
        if (is_rd && !seen) framed = 1'b0;
`endif
        cmd_valid = 1'b1;
        cmd_data  = cmd;
        for (int i = 0; i < 300; i++) begin
            rdy = cmd_ready;
            c   = cyc;
            @(posedge clk);
            if (rdy) break;
            @(negedge clk);
        end
        if (!rdy) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            acc = 0;
            return;
        end
        acc = c + 1;
        if (framed) begin
            frame_q.push_back('{cmd: cmd, len: (is_rd ? 19 + T : 11), reply: reply});
            if (is_rd) rsp_q.push_back('{data: reply, at: acc + 19 + T});
            lat = is_rd ? 20 + T + G : 12 + G;
`ifdef SPI_MASTER_SEQ_CHK_EN
            if (cmd[9:8] == 2'b10) seen = 1'b1;
            if (is_rd) seen = 1'b0;
`endif
        end else begin
            err_q.push_back(acc);
            lat = 1 + G;
        end
        @(negedge clk);
        if (wait_done) begin
            cmd_valid = 1'b0;
            cmd_data  = 10'($urandom);
            chk("busy_after_accept", 32'(busy), 1);
            chk("ready_after_accept", 32'(cmd_ready), 0);
            for (int i = 0; i < 300; i++) begin
                if (cmd_ready) break;
                @(negedge clk);
            end
            chk("ready_latency", cyc - acc + 1, lat);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("rst_ss_n", 32'(SS_n), 1);
        chk("rst_mosi", 32'(MOSI), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        frame_q.delete();
        rsp_q.delete();
        err_q.delete();
`ifdef SPI_MASTER_SEQ_CHK_EN
        seen = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int unsigned acc;
    logic [9:0]  b2b [4];
    logic [7:0]  b2b_rep [4];

    initial begin
        @(negedge clk);
        do_reset();

        send(10'h0A5, 8'h00, 1'b1, acc);
        send(10'h212, 8'h00, 1'b1, acc);
        send(10'h300, 8'hC3, 1'b1, acc);
        send(10'h17E, 8'h00, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            send({2'b10, 8'($urandom)}, 8'h00, 1'b1, acc);
            send({2'b11, 8'($urandom)}, 8'($urandom), 1'b1, acc);
        end

        // Reset during SHIFT bit 4 of an RD_DATA frame
        send(10'h2F0, 8'h00, 1'b1, acc);
        send(10'h310, 8'h77, 1'b0, acc);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mosi_bit4", 32'(MOSI), 1);
        #1;
        do_reset();
        send(10'h15A, 8'h00, 1'b1, acc);

`ifdef SPI_MASTER_SEQ_CHK_EN
        do_reset();
        send(10'h300, 8'hAA, 1'b1, acc);
        send(10'h2A1, 8'h00, 1'b1, acc);
        send(10'h3A2, 8'h96, 1'b1, acc);
`endif

        // Back-to-back with cmd_valid held high
        b2b[0] = 10'h011; b2b_rep[0] = 8'h00;
        b2b[1] = 10'h2C4; b2b_rep[1] = 8'h00;
        b2b[2] = 10'h3E7; b2b_rep[2] = 8'h3C;
        b2b[3] = 10'h1FF; b2b_rep[3] = 8'h00;
        for (int i = 0; i < 4; i++) send(b2b[i], b2b_rep[i], 1'b0, acc);
        cmd_valid = 1'b0;

        for (int i = 0; i < 300 && (frame_q.size() != 0 || rsp_q.size() != 0 || err_q.size() != 0); i++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain_frames", frame_q.size(), 0);
        chk("drain_rsp", rsp_q.size(), 0);
        chk("drain_err", err_q.size(), 0);
        chk("final_ready", 32'(cmd_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
